// File: rtl/pec_pkg.sv
// pec_pkg: shared constants and types for the performance-event snapshot packer.
// Field offsets of the packed snapshot beat (LSB first):
//   [DELTA_LSB + i*W +: W]      per-counter delta
//   [INTERVAL_LSB +: INTERVAL_W] cycles since the previous accepted capture
//   [SEQ_LSB +: SEQ_W]           snapshot sequence number
//   [AMBIG_BIT]                  interval >= 2^W, a counter may have wrapped twice
//   [DROP_BIT]                   at least one snapshot was dropped before this one
// The *_f functions give the offsets for any N/W; the localparams are the
// values for the default configuration.
package pec_pkg;

  localparam int INTERVAL_W = 16;
  localparam int SEQ_W      = 16;

  localparam int N_COUNTERS_DEF    = 115;
  localparam int COUNTER_WIDTH_DEF = 7;
  localparam int TDATA_WIDTH_DEF   = 1024;

  function automatic int interval_lsb_f(input int n, input int w);
    return n * w;
  endfunction

  function automatic int seq_lsb_f(input int n, input int w);
    return interval_lsb_f(n, w) + INTERVAL_W;
  endfunction

  function automatic int ambig_bit_f(input int n, input int w);
    return seq_lsb_f(n, w) + SEQ_W;
  endfunction

  function automatic int drop_bit_f(input int n, input int w);
    return ambig_bit_f(n, w) + 1;
  endfunction

  localparam int DELTA_LSB    = 0;
  localparam int INTERVAL_LSB = interval_lsb_f(N_COUNTERS_DEF, COUNTER_WIDTH_DEF);
  localparam int SEQ_LSB      = seq_lsb_f(N_COUNTERS_DEF, COUNTER_WIDTH_DEF);
  localparam int AMBIG_BIT    = ambig_bit_f(N_COUNTERS_DEF, COUNTER_WIDTH_DEF);
  localparam int DROP_BIT     = drop_bit_f(N_COUNTERS_DEF, COUNTER_WIDTH_DEF);

  typedef logic [TDATA_WIDTH_DEF-1:0] snapshot_t;

endpackage

// File: rtl/pec_sync_fifo.sv
// pec_sync_fifo: small synchronous FIFO with show-ahead output.
//   clk, rst   clock, asynchronous active-high reset (pointers/count only)
//   push       write push_data (ignored when full unless a pop happens too)
//   pop        drop the head entry (ignored when empty)
//   rd_data    current head entry, valid whenever empty=0
//   full/empty occupancy flags
module pec_sync_fifo
  import pec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is allowed only when the head leaves the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; the empty flag qualifies the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/pec_snapshot_packer.sv
// pec_snapshot_packer: snapshots wrapping event counters on trigger or period,
// packs per-counter deltas plus interval/seq/status into one AXI-Stream beat.
//   clk, rst        clock, asynchronous active-high reset
//   counters[N]     free-running W-bit counters (+1 per cycle at most)
//   enable          permits captures and runs the period timer
//   trigger         one-cycle capture request
//   m_axis_*        output stream, one beat (tlast=1) per snapshot
//   drop_count      saturating count of captures lost to a full buffer
module pec_snapshot_packer
  import pec_pkg::*;
#(
  parameter int N_COUNTERS    = 115,
  parameter int COUNTER_WIDTH = 7,
  parameter int PERIOD        = 64,
  parameter int TDATA_WIDTH   = 1024,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] counters [N_COUNTERS],
  input  logic                     enable,
  input  logic                     trigger,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [15:0]              drop_count
);

  localparam int N           = N_COUNTERS;
  localparam int W           = COUNTER_WIDTH;
  localparam int INT_LSB     = interval_lsb_f(N, W);
  localparam int SQ_LSB      = seq_lsb_f(N, W);
  localparam int AMB_BIT     = ambig_bit_f(N, W);
  localparam int DRP_BIT     = drop_bit_f(N, W);
  localparam int PACKED_BITS = DRP_BIT + 1;
  localparam int TW          = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PERIOD_LAST = (PERIOD > 0) ? PERIOD - 1 : 0;

  if (TDATA_WIDTH < PACKED_BITS) begin : g_width_check
    $error("TDATA_WIDTH too small for N_COUNTERS*COUNTER_WIDTH+34");
  end

  logic [W-1:0]           prev_reg [N];
  logic [TW-1:0]          timer_reg;
  logic [INTERVAL_W-1:0]  interval_reg;
  logic [SEQ_W-1:0]       seq_reg;
  logic [15:0]            drop_count_reg;
  logic                   drop_pending_reg;

  logic [N*W-1:0]         delta_flat;
  logic [TDATA_WIDTH-1:0] word_next;
  logic [TDATA_WIDTH-1:0] fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   periodic_req;
  logic                   capture_req;
  logic                   pop;
  logic                   can_push;
  logic                   accept;
  logic                   drop;
  logic                   ambiguous;

  // Modular subtraction handles a single counter wrap transparently.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_delta
    assign delta_flat[DELTA_LSB + gi*W +: W] = counters[gi] - prev_reg[gi];
  end

  // Ambiguity is impossible when a counter cannot wrap within a saturated interval.
  if (W >= INTERVAL_W) begin : g_amb_none
    assign ambiguous = 1'b0;
  end else begin : g_amb_cmp
    assign ambiguous = (interval_reg >= INTERVAL_W'(1 << W));
  end

  assign periodic_req = (PERIOD != 0) && (timer_reg == TW'(PERIOD_LAST));
  assign capture_req  = enable & (trigger | periodic_req);
  assign pop          = m_axis_tvalid & m_axis_tready;
  assign can_push     = ~fifo_full | pop;
  assign accept       = capture_req & can_push;
  assign drop         = capture_req & ~can_push;

  always_comb begin
    word_next                          = '0;
    word_next[N*W-1:0]                 = delta_flat;
    word_next[INT_LSB +: INTERVAL_W]   = interval_reg;
    word_next[SQ_LSB +: SEQ_W]         = seq_reg;
    word_next[AMB_BIT]                 = ambiguous;
    word_next[DRP_BIT]                 = drop_pending_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_reg        <= '0;
      interval_reg     <= '0;
      seq_reg          <= '0;
      drop_count_reg   <= '0;
      drop_pending_reg <= 1'b0;
    end else begin
      if (!enable || timer_reg == TW'(PERIOD_LAST)) timer_reg <= '0;
      else                                          timer_reg <= timer_reg + 1'b1;

      // A dropped capture leaves interval running so the next beat spans both.
      if (accept)                 interval_reg <= INTERVAL_W'(1);
      else if (interval_reg != '1) interval_reg <= interval_reg + 1'b1;

      if (accept) begin
        seq_reg          <= seq_reg + 1'b1;
        drop_pending_reg <= 1'b0;
      end else if (drop) begin
        drop_pending_reg <= 1'b1;
        if (drop_count_reg != '1) drop_count_reg <= drop_count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) prev_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) prev_reg[i] <= counters[i];
    end
  end

  pec_sync_fifo #(
    .WIDTH (TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (word_next),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_rd_data;
  assign m_axis_tlast  = 1'b1;
  assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_pec_snapshot_packer.sv
module tb_pec_snapshot_packer;
  import pec_pkg::*;

  localparam int N      = 115;
  localparam int W      = 7;
  localparam int PERIOD = 64;
  localparam int TDW    = 1024;
  localparam int DEPTH  = 2;

  logic            clk;
  logic            rst;
  logic [W-1:0]    counters [N];
  logic            enable;
  logic            trigger;
  logic [TDW-1:0]  m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [15:0]     drop_count;

  pec_snapshot_packer #(
    .N_COUNTERS    (N),
    .COUNTER_WIDTH (W),
    .PERIOD        (PERIOD),
    .TDATA_WIDTH   (TDW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .counters      (counters),
    .enable        (enable),
    .trigger       (trigger),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: true event totals, totals at the last accepted snapshot,
  // and cycle numbers since reset release.
  int        totals [N];
  int        snap   [N];
  int        cyc;
  int        last_acc;
  int        en_run;
  int        seq_m;
  int        drop_m;
  int        occ;
  bit        pending_m;
  snapshot_t exp_q [$];

  task automatic model_clear();
    for (int i = 0; i < N; i++) snap[i] = 0;
    cyc = 0; last_acc = 0; en_run = 0; seq_m = 0; drop_m = 0; occ = 0;
    pending_m = 1'b0;
    exp_q.delete();
  endtask

  function automatic snapshot_t build_word(input int ivl, input int sq, input bit amb, input bit drp);
    snapshot_t w;
    w = '0;
    for (int i = 0; i < N; i++) w[DELTA_LSB + i*W +: W] = W'((totals[i] - snap[i]) & ((1 << W) - 1));
    w[INTERVAL_LSB +: 16] = 16'(ivl);
    w[SEQ_LSB +: 16]      = 16'(sq);
    w[AMBIG_BIT]          = amb;
    w[DROP_BIT]           = drp;
    return w;
  endfunction

  // Apply the rules for the clock edge that just sampled (trig, en, rdy).
  task automatic model_step(input bit trig, input bit en, input bit rdy);
    bit periodic, req, pop_m, can_push;
    int ivl;
    periodic = (PERIOD > 0) ? ((en_run % PERIOD) == PERIOD - 1) : 1'b0;
    req      = en && (trig || periodic);
    pop_m    = (occ > 0) && rdy;
    can_push = (occ < DEPTH) || pop_m;
    ivl      = cyc - last_acc;
    if (ivl > 65535) ivl = 65535;
    if (req && can_push) begin
      exp_q.push_back(build_word(ivl, seq_m, ivl >= (1 << W), pending_m));
      occ++;
      seq_m     = (seq_m + 1) % 65536;
      last_acc  = cyc;
      pending_m = 1'b0;
      for (int i = 0; i < N; i++) snap[i] = totals[i];
    end else if (req) begin
      if (drop_m < 65535) drop_m++;
      pending_m = 1'b1;
    end
    if (pop_m) occ--;
    en_run = en ? en_run + 1 : 0;
    cyc++;
  endtask

  // mode: 0 = counters hold, 1 = all +1, 2 = random +0/+1
  task automatic tick(input bit trig, input bit en, input bit rdy, input int mode);
    trigger       = trig;
    enable        = en;
    m_axis_tready = rdy;
    for (int i = 0; i < N; i++) counters[i] = W'(totals[i] & ((1 << W) - 1));
    @(posedge clk);
    #1;
    model_step(trig, en, rdy);
    for (int i = 0; i < N; i++) begin
      if (mode == 1)      totals[i] = totals[i] + 1;
      else if (mode == 2) totals[i] = totals[i] + int'($urandom_range(0, 1));
    end
  endtask

  task automatic reset_mid();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_tvalid: got %0b exp 0", m_axis_tvalid);
    end
    checks++;
    if (drop_count !== 16'd0) begin
      errors++; $display("FAIL rst_drop_count: got %0d exp 0", drop_count);
    end
    checks++;
    if (m_axis_tdata !== '0) begin
      errors++; $display("FAIL rst_tdata: got nonzero exp 0");
    end
    model_clear();
    trigger = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: checks what the DUT presents against the scoreboard.
  always @(negedge clk) begin : monitor
    snapshot_t got_w, exp_w;
    int diff_i;
    if (!rst) begin
      checks++;
      if (m_axis_tvalid !== (occ > 0)) begin
        errors++; $display("FAIL tvalid: got %0b exp %0b (cycle %0d)", m_axis_tvalid, occ > 0, cyc);
      end
      checks++;
      if (drop_count !== 16'(drop_m)) begin
        errors++; $display("FAIL drop_count: got %0d exp %0d", drop_count, drop_m);
      end
      if (m_axis_tvalid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL beat_unexpected: got a beat exp none");
        end else begin
          got_w = m_axis_tdata;
          exp_w = exp_q[0];
          if (got_w !== exp_w) begin
            errors++;
            diff_i = -1;
            for (int i = N - 1; i >= 0; i--)
              if (got_w[i*W +: W] !== exp_w[i*W +: W]) diff_i = i;
            $display("FAIL beat_data: got seq=%0d ivl=%0d amb=%0b drp=%0b exp seq=%0d ivl=%0d amb=%0b drp=%0b first_delta_diff=%0d",
                     got_w[SEQ_LSB +: 16], got_w[INTERVAL_LSB +: 16], got_w[AMBIG_BIT], got_w[DROP_BIT],
                     exp_w[SEQ_LSB +: 16], exp_w[INTERVAL_LSB +: 16], exp_w[AMBIG_BIT], exp_w[DROP_BIT], diff_i);
          end
          checks++;
          if (m_axis_tlast !== 1'b1) begin
            errors++; $display("FAIL tlast: got %0b exp 1", m_axis_tlast);
          end
          if (m_axis_tready === 1'b1) begin
            $display("beat seq=%0d interval=%0d ambiguous=%0b dropped=%0b d0=%0d",
                     exp_w[SEQ_LSB +: 16], exp_w[INTERVAL_LSB +: 16], exp_w[AMBIG_BIT],
                     exp_w[DROP_BIT], exp_w[0 +: W]);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    trigger       = 1'b0;
    enable        = 1'b0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < N; i++) totals[i] = int'($urandom_range(0, 127));
    totals[0] = 5;
    totals[3] = 110;
    for (int i = 0; i < N; i++) counters[i] = W'(totals[i]);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || drop_count !== 16'd0 || m_axis_tdata !== '0) begin
      errors++; $display("FAIL reset_state: got tvalid=%0b drop=%0d exp 0/0", m_axis_tvalid, drop_count);
    end
    rst = 1'b0;

    // Basic delta at cycle 10, then counter 3 wraps 120 -> 4 at cycle 22.
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b1, 1'b1, 1);
    tick(1'b1, 1'b1, 1'b1, 1);
    for (int c = 0; c < 11; c++) tick(1'b0, 1'b1, 1'b1, 1);
    tick(1'b1, 1'b1, 1'b1, 1);

    // Long quiet interval -> ambiguous flag.
    for (int c = 0; c < 200; c++) tick(1'b0, 1'b0, 1'b1, 2);
    tick(1'b1, 1'b1, 1'b1, 2);
    tick(1'b0, 1'b1, 1'b1, 2);

    // Backpressure: three triggers into a 2-entry buffer, then trigger with pop.
    for (int t = 0; t < 3; t++) begin
      tick(1'b1, 1'b1, 1'b0, 2);
      tick(1'b0, 1'b1, 1'b0, 2);
    end
    tick(1'b1, 1'b1, 1'b1, 2);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 1'b1, 2);

    // Full buffer, capture in the same cycle as a pop.
    tick(1'b1, 1'b1, 1'b0, 2);
    tick(1'b1, 1'b1, 1'b0, 2);
    tick(1'b1, 1'b1, 1'b1, 2);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 1'b1, 2);

    // Periodic captures only.
    for (int c = 0; c < 200; c++) tick(1'b0, 1'b1, 1'b1, 2);

    // Randomised traffic with a reset mid-stream.
    for (int it = 0; it < 2000; it++) begin
      if (it == 1000) begin
        tick(1'b1, 1'b1, 1'b0, 2);
        tick(1'b1, 1'b1, 1'b0, 2);
        tick(1'b1, 1'b1, 1'b0, 2);
        reset_mid();
      end
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, 2);
    end

    // Drain.
    for (int c = 0; c < 6; c++) tick(1'b0, 1'b0, 1'b1, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d beats left exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
